// File: rtl/soc_ram_arbiter_if.sv
// Master-side bus into the RAM arbiter: one level request per beat, held with
// its address, write enable, data and byte mask until ack. Read data comes
// back one cycle after the accepting ack as a registered rvalid pulse.
interface soc_ram_arbiter_if #(
  parameter int AW = 14
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    wmask;
  logic          ack;
  logic          rvalid;
  logic [31:0]   rdata;

  // Requesting master (cpu6 load/store port or VGA scan fetch)
  modport master (
    output req, we, addr, wdata, wmask,
    input  ack, rvalid, rdata
  );

  // Arbiter side
  modport slave (
    input  req, we, addr, wdata, wmask,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/soc_ram_arbiter.sv
// Round-robin arbiter sharing the single-port SoC data RAM between M0 (cpu6)
// and M1 (VGA fetch). Grants are registered, bursts are capped at BURST_MAX
// beats, and read data is steered back to the master that issued the read.
//
// Handshake: a beat happens in a cycle where the arbiter is in GNTx and
// mx.req=1; mx.ack is then 1 in that same cycle and the master may change or
// drop its request after the clock edge. A read beat produces mx.rvalid=1 in
// the following cycle with the data on mx.rdata; writes produce no rvalid.
//
// dbg_state_o encoding: 0 = IDLE, 1 = GNT0, 2 = GNT1.
module soc_ram_arbiter #(
  parameter  int AW        = 14,
  parameter  int BURST_MAX = 8,
  localparam int CW        = $clog2(BURST_MAX + 1)
) (
  input  logic                clk,
  input  logic                reset,
  soc_ram_arbiter_if.slave    m0,
  soc_ram_arbiter_if.slave    m1,
  output logic                ram_en,
  output logic [3:0]          ram_we,
  output logic [AW-1:0]       ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata,
  output logic [1:0]          dbg_state_o,
  output logic                dbg_last_owner_o,
  output logic [CW-1:0]       dbg_beat_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);

  state_t        state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]    rd_tag_q, rd_tag_d;

  // Current owner's request fields (owner is M1 only in GNT1)
  logic          own_sel;
  logic          own_req;
  logic          own_we;
  logic [AW-1:0] own_addr;
  logic [31:0]   own_wdata;
  logic [3:0]    own_wmask;
  logic          other_req;
  logic          beat;

  assign own_sel   = (state_q == GNT1);
  assign own_req   = own_sel ? m1.req   : m0.req;
  assign own_we    = own_sel ? m1.we    : m0.we;
  assign own_addr  = own_sel ? m1.addr  : m0.addr;
  assign own_wdata = own_sel ? m1.wdata : m0.wdata;
  assign own_wmask = own_sel ? m1.wmask : m0.wmask;
  assign other_req = own_sel ? m0.req   : m1.req;

  // Next-state, burst accounting and RAM strobe generation
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    rd_tag_d     = 2'b00;
    beat         = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 4'b0000;
    ram_addr     = own_addr;
    ram_wdata    = own_wdata;

    case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        // Tie goes to whichever master did not own the bus last
        if (m0.req && m1.req) begin
          state_d = last_owner_q ? GNT0 : GNT1;
        end else if (m0.req) begin
          state_d = GNT0;
        end else if (m1.req) begin
          state_d = GNT1;
        end
      end

      GNT0, GNT1: begin
        if (own_req) begin
          beat         = 1'b1;
          ram_en       = 1'b1;
          ram_we       = own_we ? own_wmask : 4'b0000;
          last_owner_d = own_sel;
          rd_tag_d     = own_sel ? {~own_we, 1'b0} : {1'b0, ~own_we};
          if (beat_cnt_q == LAST_BEAT) begin
            // Burst limit: hand over if the other side waits, else re-arm
            beat_cnt_d = '0;
            if (other_req) begin
              state_d = own_sel ? GNT0 : GNT1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end else begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end
      end

      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase

    // Nothing reaches the RAM while reset is held
    if (reset) begin
      beat   = 1'b0;
      ram_en = 1'b0;
      ram_we = 4'b0000;
    end
  end

  // Arbitration state and read-return tag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      rd_tag_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  // Ack is combinational from the grant; rvalid is the registered read tag,
  // masked during reset so an in-flight read is dropped silently.
  assign m0.ack    = beat & ~own_sel;
  assign m1.ack    = beat &  own_sel;
  assign m0.rvalid = rd_tag_q[0] & ~reset;
  assign m1.rvalid = rd_tag_q[1] & ~reset;
  assign m0.rdata  = ram_rdata;
  assign m1.rdata  = ram_rdata;

  assign dbg_state_o      = state_q;
  assign dbg_last_owner_o = last_owner_q;
  assign dbg_beat_cnt_o   = beat_cnt_q;

endmodule

// File: tb/tb_soc_ram_arbiter.sv
// Bench for soc_ram_arbiter: write-first RAM model, scripted scenarios with
// arithmetic expectations, and a randomized run scored against a shadow memory.
module tb_soc_ram_arbiter;
  localparam int AW        = 14;
  localparam int BURST_MAX = 8;
  localparam int CW        = $clog2(BURST_MAX + 1);
  localparam logic [1:0] ST_IDLE = 2'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  soc_ram_arbiter_if #(.AW(AW)) m0_bus ();
  soc_ram_arbiter_if #(.AW(AW)) m1_bus ();

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [1:0]    dbg_state;
  logic          dbg_last_owner;
  logic [CW-1:0] dbg_beat_cnt;

  soc_ram_arbiter #(.AW(AW), .BURST_MAX(BURST_MAX)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0               (m0_bus),
    .m1               (m1_bus),
    .ram_en           (ram_en),
    .ram_we           (ram_we),
    .ram_addr         (ram_addr),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata),
    .dbg_state_o      (dbg_state),
    .dbg_last_owner_o (dbg_last_owner),
    .dbg_beat_cnt_o   (dbg_beat_cnt)
  );

  int total;
  int bad;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] m);
    merge_bytes = old_v;
    for (int b = 0; b < 4; b++) if (m[b]) merge_bytes[8*b +: 8] = new_v[8*b +: 8];
  endfunction

  // ---------------- RAM model (write-first, 1-cycle read) ----------------
  logic [31:0]   ram_mem [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  logic [31:0]   merged;
  always @(posedge clk) begin
    if (pl_en) begin
      ram_mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      if (ram_we != 4'b0000) begin
        merged = merge_bytes(ram_mem[ram_addr], ram_wdata, ram_we);
        ram_mem[ram_addr] <= merged;
        ram_rdata <= merged;
      end else begin
        ram_rdata <= ram_mem[ram_addr];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] model_mem [int];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] burst_val [4];
  logic [31:0] stream_val [20];

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    m0_bus.req = r; m0_bus.we = w; m0_bus.addr = a; m0_bus.wdata = d; m0_bus.wmask = m;
  endtask

  task automatic drive_m1(input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] m);
    m1_bus.req = r; m1_bus.we = w; m1_bus.addr = a; m1_bus.wdata = d; m1_bus.wmask = m;
  endtask

  task automatic idle_both();
    drive_m0(1'b0, 1'b0, '0, 32'h0, 4'h0);
    drive_m1(1'b0, 1'b0, '0, 32'h0, 4'h0);
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    pl_en = 1'b1; pl_addr = AW'(a); pl_data = v;
    model_mem[a] = v;
    next_cycle();
    pl_en = 1'b0;
  endtask

  task automatic preload_all();
    preload(32'h010, 32'hdeadbeef);
    preload(32'h020, 32'hffffffff);
    for (int i = 0; i < 4; i++) begin
      burst_val[i] = $urandom;
      preload(32'h100 + i, burst_val[i]);
    end
    for (int i = 0; i < 20; i++) begin
      stream_val[i] = $urandom;
      preload(32'h200 + i, stream_val[i]);
    end
    for (int i = 0; i < 16; i++) preload(i, $urandom);
  endtask

  task automatic new_txn(input int read_bias, output logic w, output logic [AW-1:0] a,
                         output logic [31:0] d, output logic [3:0] m);
    w = ($urandom_range(0, 3) >= read_bias);
    a = AW'($urandom_range(0, 15));
    d = $urandom;
    m = 4'($urandom_range(1, 15));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_m0(1'b1, 1'b0, AW'(32'h010), 32'h0, 4'h0);
    drive_m1(1'b1, 1'b0, AW'(32'h020), 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL rst_ack0 got=%b want=0", m0_bus.ack); end
    total++; if (m1_bus.ack !== 1'b0) begin bad++; $display("FAIL rst_ack1 got=%b want=0", m1_bus.ack); end
    total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en got=%b want=0", ram_en); end
    total++; if (ram_we !== 4'b0) begin bad++; $display("FAIL rst_ram_we got=%b want=0000", ram_we); end
    total++; if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b00) begin bad++;
      $display("FAIL rst_rvalid got=%b want=00", {m0_bus.rvalid, m1_bus.rvalid}); end
    next_cycle();
    idle_both();
    reset = 1'b0;
    @(negedge clk);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    total++; if (dbg_last_owner !== 1'b1) begin bad++; $display("FAIL rst_last_owner got=%b want=1", dbg_last_owner); end
    total++; if (dbg_beat_cnt !== '0) begin bad++; $display("FAIL rst_beat_cnt got=%0d want=0", dbg_beat_cnt); end
    next_cycle();
  endtask

  task automatic test_single_read();
    drive_m0(1'b1, 1'b0, AW'(32'h010), 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL rd_t0_ack got=%b want=0", m0_bus.ack); end
    next_cycle();
    @(negedge clk);
    total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL rd_t1_ack got=%b want=1", m0_bus.ack); end
    total++; if (ram_addr !== AW'(32'h010)) begin bad++; $display("FAIL rd_t1_addr got=%h want=010", ram_addr); end
    next_cycle();
    drive_m0(1'b0, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m0_bus.rvalid !== 1'b1) begin bad++; $display("FAIL rd_t2_rvalid got=%b want=1", m0_bus.rvalid); end
    total++; if (m0_bus.rdata !== 32'hdeadbeef) begin bad++; $display("FAIL rd_t2_rdata got=%h want=deadbeef", m0_bus.rdata); end
    total++; if (m1_bus.rvalid !== 1'b0) begin bad++; $display("FAIL rd_t2_m1_rvalid got=%b want=0", m1_bus.rvalid); end
    next_cycle();
  endtask

  task automatic test_masked_write();
    drive_m0(1'b1, 1'b1, AW'(32'h020), 32'h12345678, 4'b0011);
    @(negedge clk);
    total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL wr_arb_ack got=%b want=0", m0_bus.ack); end
    next_cycle();
    @(negedge clk);
    total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL wr_ack got=%b want=1", m0_bus.ack); end
    total++; if (ram_we !== 4'b0011) begin bad++; $display("FAIL wr_ram_we got=%b want=0011", ram_we); end
    next_cycle();
    drive_m0(1'b1, 1'b0, AW'(32'h020), 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL raw_ack got=%b want=1", m0_bus.ack); end
    total++; if (ram_we !== 4'b0000) begin bad++; $display("FAIL raw_ram_we got=%b want=0000", ram_we); end
    total++; if (m0_bus.rvalid !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%b want=0", m0_bus.rvalid); end
    next_cycle();
    drive_m0(1'b0, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m0_bus.rvalid !== 1'b1) begin bad++; $display("FAIL raw_rvalid got=%b want=1", m0_bus.rvalid); end
    total++; if (m0_bus.rdata !== 32'hffff5678) begin bad++; $display("FAIL raw_rdata got=%h want=ffff5678", m0_bus.rdata); end
    model_mem[32'h020] = 32'hffff5678;
    next_cycle();
  endtask

  task automatic test_m1_burst();
    drive_m1(1'b1, 1'b0, AW'(32'h100), 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m1_bus.ack !== 1'b0) begin bad++; $display("FAIL bst_arb_ack got=%b want=0", m1_bus.ack); end
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if ({m0_bus.ack, m1_bus.ack} !== 2'b01) begin bad++;
        $display("FAIL bst_ack beat=%0d got=%b want=01", i, {m0_bus.ack, m1_bus.ack}); end
      total++; if (ram_addr !== AW'(32'h100 + i)) begin bad++;
        $display("FAIL bst_addr beat=%0d got=%h want=%h", i, ram_addr, 32'h100 + i); end
      if (i > 0) begin
        total++; if (m1_bus.rvalid !== 1'b1 || m1_bus.rdata !== burst_val[i-1]) begin bad++;
          $display("FAIL bst_rdata beat=%0d got=%b/%h want=1/%h", i-1, m1_bus.rvalid, m1_bus.rdata, burst_val[i-1]); end
      end
      next_cycle();
      if (i < 3) drive_m1(1'b1, 1'b0, AW'(32'h100 + i + 1), 32'h0, 4'h0);
      else drive_m1(1'b0, 1'b0, '0, 32'h0, 4'h0);
    end
    @(negedge clk);
    total++; if (m1_bus.ack !== 1'b0) begin bad++; $display("FAIL bst_drop_ack got=%b want=0", m1_bus.ack); end
    total++; if (m1_bus.rvalid !== 1'b1 || m1_bus.rdata !== burst_val[3]) begin bad++;
      $display("FAIL bst_rdata beat=3 got=%b/%h want=1/%h", m1_bus.rvalid, m1_bus.rdata, burst_val[3]); end
    next_cycle();
    @(negedge clk);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL bst_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    total++; if (dbg_last_owner !== 1'b1) begin bad++; $display("FAIL bst_last_owner got=%b want=1", dbg_last_owner); end
    total++; if (m1_bus.rvalid !== 1'b0) begin bad++; $display("FAIL bst_extra_rvalid got=%b want=0", m1_bus.rvalid); end
    next_cycle();
  endtask

  task automatic test_both_fair();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive_m0(1'b1, 1'b0, AW'(32'h010), 32'h0, 4'h0);
    drive_m1(1'b1, 1'b0, AW'(32'h020), 32'h0, 4'h0);
    @(negedge clk);
    total++; if ({m0_bus.ack, m1_bus.ack} !== 2'b00) begin bad++;
      $display("FAIL fair_arb got=%b want=00", {m0_bus.ack, m1_bus.ack}); end
    next_cycle();
    // Beat k belongs to M0 in even blocks of BURST_MAX, M1 in odd ones
    for (int k = 0; k < 4 * BURST_MAX; k++) begin
      int owner;
      owner = (k / BURST_MAX) % 2;
      @(negedge clk);
      total++;
      if (m0_bus.ack !== (owner == 0) || m1_bus.ack !== (owner == 1)) begin bad++;
        $display("FAIL fair_beat k=%0d got=%b%b want=%b%b", k, m0_bus.ack, m1_bus.ack, owner == 0, owner == 1); end
      next_cycle();
    end
    idle_both();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_midread();
    drive_m1(1'b1, 1'b0, AW'(32'h101), 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m1_bus.ack !== 1'b0) begin bad++; $display("FAIL rmr_arb_ack got=%b want=0", m1_bus.ack); end
    next_cycle();
    @(negedge clk);
    total++; if (m1_bus.ack !== 1'b1) begin bad++; $display("FAIL rmr_ack got=%b want=1", m1_bus.ack); end
    next_cycle();
    reset = 1'b1;
    drive_m1(1'b0, 1'b0, '0, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m1_bus.rvalid !== 1'b0) begin bad++; $display("FAIL rmr_rvalid_in_rst got=%b want=0", m1_bus.rvalid); end
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    total++; if (m1_bus.rvalid !== 1'b0) begin bad++; $display("FAIL rmr_rvalid_after got=%b want=0", m1_bus.rvalid); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rmr_state got=%0d want=%0d", dbg_state, ST_IDLE); end
    next_cycle();
    drive_m0(1'b1, 1'b0, AW'(32'h010), 32'h0, 4'h0);
    drive_m1(1'b1, 1'b0, AW'(32'h100), 32'h0, 4'h0);
    @(negedge clk);
    total++; if ({m0_bus.ack, m1_bus.ack} !== 2'b00) begin bad++;
      $display("FAIL rmr_arb got=%b want=00", {m0_bus.ack, m1_bus.ack}); end
    next_cycle();
    @(negedge clk);
    total++; if ({m0_bus.ack, m1_bus.ack} !== 2'b10) begin bad++;
      $display("FAIL rmr_first_grant got=%b want=10", {m0_bus.ack, m1_bus.ack}); end
    next_cycle();
    idle_both();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_m0_stream();
    int n_ack;
    int n_rv;
    n_ack = 0;
    n_rv = 0;
    drive_m0(1'b1, 1'b0, AW'(32'h200), 32'h0, 4'h0);
    @(negedge clk);
    total++; if (m0_bus.ack !== 1'b0) begin bad++; $display("FAIL str_arb_ack got=%b want=0", m0_bus.ack); end
    next_cycle();
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (m0_bus.ack === 1'b1) n_ack++;
      if (m0_bus.rvalid === 1'b1) n_rv++;
      if (i < 20) begin
        total++; if (m0_bus.ack !== 1'b1) begin bad++; $display("FAIL str_ack i=%0d got=%b want=1", i, m0_bus.ack); end
      end
      if (i > 0) begin
        total++; if (m0_bus.rvalid !== 1'b1 || m0_bus.rdata !== stream_val[i-1]) begin bad++;
          $display("FAIL str_rdata i=%0d got=%b/%h want=1/%h", i-1, m0_bus.rvalid, m0_bus.rdata, stream_val[i-1]); end
      end
      next_cycle();
      if (i < 19) drive_m0(1'b1, 1'b0, AW'(32'h200 + i + 1), 32'h0, 4'h0);
      else drive_m0(1'b0, 1'b0, '0, 32'h0, 4'h0);
    end
    total++; if (n_ack != 20) begin bad++; $display("FAIL str_ack_count got=%0d want=20", n_ack); end
    total++; if (n_rv != 20) begin bad++; $display("FAIL str_rvalid_count got=%0d want=20", n_rv); end
    next_cycle();
  endtask

  task automatic test_random();
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    m;
    logic          a0, a1;
    int            wait0, wait1;
    // A held request waits through at most the other master's burst, plus the
    // dropped-request cycle and the IDLE arbitration cycle when the burst ends early.
    int            wait_max;
    wait_max = BURST_MAX + 2;
    wait0 = 0;
    wait1 = 0;
    idle_both();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      a0 = m0_bus.ack;
      a1 = m1_bus.ack;
      total++; if (a0 && a1) begin bad++; $display("FAIL rnd_dual_ack cyc=%0d got=11 want=one-hot", cyc); end
      if (m0_bus.rvalid) begin
        total++;
        if (exp_q0.size() == 0) begin bad++; $display("FAIL rnd_m0_spurious_rvalid cyc=%0d got=1 want=0", cyc); end
        else begin
          logic [31:0] e;
          e = exp_q0.pop_front();
          if (m0_bus.rdata !== e) begin bad++; $display("FAIL rnd_m0_rdata cyc=%0d got=%h want=%h", cyc, m0_bus.rdata, e); end
        end
      end
      if (m1_bus.rvalid) begin
        total++;
        if (exp_q1.size() == 0) begin bad++; $display("FAIL rnd_m1_spurious_rvalid cyc=%0d got=1 want=0", cyc); end
        else begin
          logic [31:0] e;
          e = exp_q1.pop_front();
          if (m1_bus.rdata !== e) begin bad++; $display("FAIL rnd_m1_rdata cyc=%0d got=%h want=%h", cyc, m1_bus.rdata, e); end
        end
      end
      if (m0_bus.req && !a0) wait0++;
      if (m1_bus.req && !a1) wait1++;
      if (a0) begin
        total++; if (wait0 > wait_max) begin bad++; $display("FAIL rnd_m0_wait got=%0d want<=%0d", wait0, wait_max); end
        if (m0_bus.we) model_mem[int'(m0_bus.addr)] = merge_bytes(model_mem[int'(m0_bus.addr)], m0_bus.wdata, m0_bus.wmask);
        else exp_q0.push_back(model_mem[int'(m0_bus.addr)]);
      end
      if (a1) begin
        total++; if (wait1 > wait_max) begin bad++; $display("FAIL rnd_m1_wait got=%0d want<=%0d", wait1, wait_max); end
        if (m1_bus.we) model_mem[int'(m1_bus.addr)] = merge_bytes(model_mem[int'(m1_bus.addr)], m1_bus.wdata, m1_bus.wmask);
        else exp_q1.push_back(model_mem[int'(m1_bus.addr)]);
      end
      if (wait0 > 50 || wait1 > 50) begin
        total++; bad++;
        $display("FAIL rnd_starved got=%0d/%0d want<=%0d", wait0, wait1, wait_max);
        break;
      end
      next_cycle();
      if (a0 || !m0_bus.req) begin
        wait0 = 0;
        if ($urandom_range(0, 3) != 0) begin new_txn(2, w, a, d, m); drive_m0(1'b1, w, a, d, m); end
        else drive_m0(1'b0, 1'b0, '0, 32'h0, 4'h0);
      end
      if (a1 || !m1_bus.req) begin
        wait1 = 0;
        if ($urandom_range(0, 3) != 0) begin new_txn(3, w, a, d, m); drive_m1(1'b1, w, a, d, m); end
        else drive_m1(1'b0, 1'b0, '0, 32'h0, 4'h0);
      end
    end
    idle_both();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (m0_bus.rvalid && exp_q0.size() > 0) begin
        logic [31:0] e;
        e = exp_q0.pop_front();
        total++; if (m0_bus.rdata !== e) begin bad++; $display("FAIL rnd_m0_drain got=%h want=%h", m0_bus.rdata, e); end
      end
      if (m1_bus.rvalid && exp_q1.size() > 0) begin
        logic [31:0] e;
        e = exp_q1.pop_front();
        total++; if (m1_bus.rdata !== e) begin bad++; $display("FAIL rnd_m1_drain got=%h want=%h", m1_bus.rdata, e); end
      end
      next_cycle();
    end
    total++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin bad++;
      $display("FAIL rnd_pending_reads got=%0d/%0d want=0/0", exp_q0.size(), exp_q1.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    idle_both();
    next_cycle();
    next_cycle();
    preload_all();
    test_reset();
    test_single_read();
    test_masked_write();
    test_m1_burst();
    test_both_fair();
    test_reset_midread();
    test_m0_stream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
